// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
// MULT/MULTU use radix-2 shift-add over 32 steps, and DIV/DIVU use restoring
// division over 32 steps. A final FIX cycle applies the sign correction and
// writes HI/LO.
// Optional build macro MULT_DIV_FAST_MULT_EN: multiplies skip CALC and go
// straight to FIX. There a combinational 32x32 multiplier produces the result,
// so hi/lo land one edge after start. Division is unaffected by the macro.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wrdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        div_q;       // captured op is a divide
  logic        neg_q;       // product / quotient must be negated
  logic        neg_rem_q;   // remainder must be negated (dividend was negative)
  logic [31:0] a_q;         // raw dividend, returned as remainder on divide-by-zero
  logic [63:0] prod;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;

  logic        sgn_op;
  logic [31:0] a_abs, b_abs;
  logic [32:0] div_shift, div_diff;
  logic [63:0] mul_src;
  logic [31:0] hi_res, lo_res;

  // Magnitude of a 32-bit operand when treated as signed.
  function automatic logic [31:0] abs_val(input logic [31:0] x, input logic sgn);
    logic signed [31:0] sx;
    sx = x;
    return (sgn && sx < 0) ? 32'(-sx) : x;
  endfunction

  // Conditional two's-complement negation used by the sign fix-up.
  function automatic logic [31:0] neg32(input logic [31:0] x, input logic n);
    return n ? 32'(-x) : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x, input logic n);
    return n ? 64'(-x) : x;
  endfunction

  assign busy = (state != IDLE);

  // Operand conditioning at the start edge: signed ops (op[0]=0) work on magnitudes.
  always_comb begin
    sgn_op = ~op[0];
    a_abs  = abs_val(a, sgn_op);
    b_abs  = abs_val(b, sgn_op);
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    div_shift = {rem, quo[31]};
    div_diff  = div_shift - {1'b0, dvsr};
  end

  // Final result selection and sign correction for the FIX cycle.
  always_comb begin
`ifdef MULT_DIV_FAST_MULT_EN
    mul_src = {32'd0, mcand[31:0]} * {32'd0, mplier};
`else
    mul_src = prod;
`endif
    {hi_res, lo_res} = neg64(mul_src, neg_q);
    if (div_q) begin
      if (dvsr == 32'd0) begin
        hi_res = a_q;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        hi_res = neg32(rem, neg_rem_q);
        lo_res = neg32(quo, neg_q);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULT_DIV_FAST_MULT_EN
          state_nx = op[1] ? CALC : FIX;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC:    if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, HI/LO registers and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      done      <= 1'b0;
      cnt       <= 5'd0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= 32'd0;
      prod      <= 64'd0;
      mcand     <= 64'd0;
      mplier    <= 32'd0;
      rem       <= 32'd0;
      quo       <= 32'd0;
      dvsr      <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= 5'd0;
            div_q     <= op[1];
            a_q       <= a;
            neg_q     <= sgn_op & (a[31] ^ b[31]);
            neg_rem_q <= sgn_op & a[31];
            prod      <= 64'd0;
            mcand     <= {32'd0, a_abs};
            mplier    <= b_abs;
            rem       <= 32'd0;
            quo       <= a_abs;
            dvsr      <= b_abs;
          end else begin
            if (hi_we) hi <= wrdata;
            if (lo_we) lo <= wrdata;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (div_q) begin
            if (!div_diff[32]) begin
              rem <= div_diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= div_shift[31:0];
              quo <= {quo[30:0], 1'b0};
            end
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
          end
        end
        FIX: begin
          hi   <= hi_res;
          lo   <= lo_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pairs are queued when an
// operation is started and compared when done pulses.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wrdata = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] sb[$];
  logic [63:0] last_res = 64'd0;

`ifdef MULT_DIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wrdata(wrdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference results built from native SV arithmetic: {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return (FAST && !o[1]) ? 2 : 34;
  endfunction

  // Called at a negedge; the next posedge is the start edge E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    start = 1'b1; op = o; a = x; b = y;
    if (push) sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  // Waits (bounded) for done, then checks latency, busy and the scoreboard entry.
  task automatic wait_done(input int lat);
    int  cyc;
    bit  seen;
    logic [63:0] e;
    seen = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("latency", cyc, lat);
      check("busy_at_done", busy, 0);
      check("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        last_res = e;
        check("hi", hi, e[63:32]);
        check("lo", lo, e[31:0]);
      end
    end else begin
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start_op(o, x, y, 1'b1);
    wait_done(exp_lat(o));
  endtask

  initial begin
    int dones;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // MTHI / MTLO
    hi_we = 1'b1; lo_we = 1'b1; wrdata = 32'hAAAA_5555;
    @(negedge clk);
    lo_we = 1'b1; hi_we = 1'b0; wrdata = 32'h1234_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", hi, 32'hAAAA_5555);
    check("mtlo", lo, 32'h1234_5678);

    // Directed operations, chained so each start lands in the previous done cycle
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run(2'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run(2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run(2'd3, 32'd100, 32'd0);
    check("divu_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run(2'd2, 32'hFFFF_FF00, 32'd0);
    run(2'd2, 32'd17, 32'hFFFF_FFFB);
    run(2'd0, 32'h8000_0000, 32'h8000_0000);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i == 5) rb = 32'd0;
      if (i % 2 == 1) rb = -rb;
      run(ro, ra, rb);
    end

    // MTHI in the same cycle as start is dropped
    hi_we = 1'b1; wrdata = 32'hDEAD_BEEF;
    start_op(2'd1, 32'd3, 32'd4, 1'b1);
    hi_we = 1'b0;
    check("mthi_vs_start", hi, last_res[63:32]);
    wait_done(exp_lat(2'd1));

    // start and hi_we while busy are ignored; a single done pulse
    start_op(2'd3, 32'd1000, 32'd7, 1'b1);
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
        hi_we = 1'b1; wrdata = 32'h0000_1234;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (done) begin
        dones++;
        check("busy_ign_lat", c, 34);
        if (sb.size() > 0) begin
          last_res = sb.pop_front();
          check("busy_ign_hi", hi, last_res[63:32]);
          check("busy_ign_lo", lo, last_res[31:0]);
        end
      end
    end
    check("busy_ign_dones", dones, 1);
    check("busy_ign_result", {hi, lo}, {32'd6, 32'd142});

    // Reset during CALC aborts
    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    // Unit is usable after the abort
    run(2'd3, 32'd77, 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: sim time exceeded, %0d of %0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the clock and rst is the reset.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin the operation selected by op, sampled on a rising edge
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  operand rs (multiplicand or dividend), driven from register-file data1
- b  in  32  operand rt (multiplier or divisor), driven from register-file data2
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wrdata  in  32  MTHI/MTLO data
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Function
REQ-003 The block SHALL implement the states IDLE, CALC and FIX, with busy=1 exactly when the state is not IDLE.
REQ-004 In IDLE, the block SHALL accept start=1 on a rising edge (E0) and on that edge: capture a, b and op, load |a| and |b| (signed ops) or a and b (unsigned ops), record the result signs, clear the 5-bit step counter, and enter CALC.
REQ-005 In CALC, the block SHALL perform one step per cycle and leave for FIX when the counter reaches 31, which gives 32 steps on edges E1..E32.
- Multiply: radix-2 shift-add, producing a 64-bit unsigned product.
- Divide: restoring division, producing a 32-bit quotient and remainder.
REQ-006 In FIX (edge E33), the block SHALL apply the sign correction, write hi/lo, and return to IDLE.
- Signed multiply: the product is negated if sign(a)≠sign(b).
- Signed divide: the quotient is negated if sign(a)≠sign(b), and the remainder takes the sign of a.
REQ-007 The result mapping SHALL be: multiply gives {hi,lo} = 64-bit product; divide gives lo = quotient and hi = remainder.
REQ-008 done SHALL be a registered pulse that is 1 for exactly the cycle after hi/lo update; busy SHALL be 0 in that same cycle.
REQ-009 start SHALL be ignored while busy=1.
- A start in the done cycle SHALL be accepted.
REQ-010 hi_we and lo_we SHALL each load wrdata into hi or lo on the rising edge, but only in IDLE with start=0.
- hi_we and lo_we SHALL be ignored while busy=1.
- If start=1 arrives in the same cycle as hi_we or lo_we, start SHALL win and the writes SHALL be dropped.
REQ-011 A divisor of 0 SHALL give hi = a and lo = 0xFFFFFFFF, with no sign fix-up and normal latency.
REQ-012 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000.
REQ-013 The operands captured at E0 SHALL be the only values used; a and b MAY change afterwards.

Reset
REQ-014 With rst=1 on a rising edge, the block SHALL set state to IDLE, hi = 0, lo = 0, busy = 0, done = 0, and clear the counter and datapath registers.
REQ-015 Reset SHALL take priority over start, hi_we and lo_we.
REQ-016 A reset during CALC or FIX SHALL abort the operation with no done pulse and no hi/lo update other than clearing them.

Configuration
REQ-017 The macro MULT_DIV_FAST_MULT_EN SHALL control the multiply path.
- Defined: MULT and MULTU SHALL compute in one cycle with a combinational 32x32 multiplier; hi/lo are written at E1, busy=1 only between E0 and E1, and done=1 in the cycle after E1.
- Defined: division SHALL be unchanged.
- Undefined: all operations SHALL use the iterative path with hi/lo written at E33.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 34 cycles after the start edge (2 cycles with MULT_DIV_FAST_MULT_EN).
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, done at normal latency.
- Start a DIVU, then during busy pulse start and hi_we with wrdata=0x1234 -> both ignored; the original result lands with a single done pulse.
- Start a MULTU, assert rst 10 cycles later -> busy=0, hi=lo=0 on the next cycle; no done for 40 cycles.
